// File: rtl/sample_rd_addr_pkg.sv
// Shared definitions for the sample-memory address sequencers (read and write side).
// Holds default geometry and the read sequencer state encoding.
package sample_rd_addr_pkg;

    localparam int BIT_ADDR = 9;
    localparam int BIT_DATA = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/sample_rd_addr_if.sv
// Control, RAM read port and output stream of the read sequencer.
// slave = sequencer side, master = requester / RAM / downstream side.
interface sample_rd_addr_if
    import sample_rd_addr_pkg::*;
#(
    parameter int bit_addr = BIT_ADDR,
    parameter int bit_data = BIT_DATA
) ();

    logic                start;
    logic                abort;
    logic [bit_addr-1:0] base;
    logic [bit_addr:0]   len;
    logic                busy;
    logic                rd_en;
    logic [bit_addr-1:0] rd_addr;
    logic [bit_data-1:0] rd_data;
    logic                out_valid;
    logic [bit_data-1:0] out_data;
    logic                out_last;
    logic                out_ready;
    logic                done;

    modport slave (
        input  start, abort, base, len, rd_data, out_ready,
        output busy, rd_en, rd_addr, out_valid, out_data, out_last, done
    );

    modport master (
        output start, abort, base, len, rd_data, out_ready,
        input  busy, rd_en, rd_addr, out_valid, out_data, out_last, done
    );

endinterface

// File: rtl/sample_rd_addr_rd_skid_fifo.sv
// 2-entry skid FIFO for returned RAM words; head visible in the cycle after the push.
// No internal backpressure: the caller guarantees no push when full and no pop when empty.
module rd_skid_fifo #(
    parameter int width = 17
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             i_push,
    input  logic [width-1:0] i_push_dat,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [1:0]       o_count,
    output logic [width-1:0] o_head_dat
);

    logic [width-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_count    = r_count;
    assign o_head_dat = r_mem[r_rd_ptr];

endmodule

// File: rtl/sample_rd_addr.sv
// Streams len words from base (wrapping) out of a 1-cycle-latency RAM onto a valid/ready stream.
// First word valid 3 cycles after start; reads are throttled so returned words always fit the skid FIFO.
module sample_rd_addr
    import sample_rd_addr_pkg::*;
#(
    parameter int bit_addr = BIT_ADDR,
    parameter int bit_data = BIT_DATA
) (
    input  logic             clk,
    input  logic             clr_n,
    sample_rd_addr_if.slave  bus
);

    localparam logic [bit_addr-1:0] ADDR_ONE = 1;
    localparam logic [bit_addr:0]   REM_ONE  = 1;

    rd_state_t           r_state;
    logic [bit_addr-1:0] r_addr;
    logic [bit_addr:0]   r_remain;
    logic                r_inflight;
    logic                r_inflight_last;
    logic                r_zero_done;

    logic [1:0]          w_count;
    logic [bit_data:0]   w_head;
    logic [2:0]          w_occ;
    logic                w_valid;
    logic                w_pop;
    logic                w_credit;
    logic                w_issue;
    logic                w_drain_done;

    assign w_valid = (w_count != 2'd0);
    assign w_pop   = w_valid & bus.out_ready;

    // A word leaving the FIFO this cycle frees its slot for the read issued now,
    // which is what allows one word per cycle with only two entries.
    assign w_occ        = {1'b0, w_count} + {2'b0, r_inflight};
    assign w_credit     = (w_occ < (3'd2 + {2'b0, w_pop}));
    assign w_issue      = (r_state == ST_RUN) && (r_remain != '0) && w_credit && !bus.abort;
    assign w_drain_done = (r_state == ST_DRAIN) && !w_valid && !r_inflight && !bus.abort;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state         <= ST_IDLE;
            r_addr          <= '0;
            r_remain        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_zero_done     <= 1'b0;
        end else begin
            r_zero_done     <= 1'b0;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_remain == REM_ONE);
            if (bus.abort) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            if (bus.len != '0) begin
                                r_addr   <= bus.base;
                                r_remain <= bus.len;
                                r_state  <= ST_RUN;
                            end else begin
                                r_zero_done <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (w_issue) begin
                            r_addr   <= r_addr + ADDR_ONE;
                            r_remain <= r_remain - REM_ONE;
                            if (r_remain == REM_ONE) begin
                                r_state <= ST_DRAIN;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (w_drain_done) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Abort flushes the FIFO; a read returning in the abort cycle is dropped by the flush.
    rd_skid_fifo #(
        .width (bit_data + 1)
    ) u_fifo (
        .clk        (clk),
        .clr_n      (clr_n),
        .i_push     (r_inflight),
        .i_push_dat ({r_inflight_last, bus.rd_data}),
        .i_pop      (w_pop),
        .i_flush    (bus.abort),
        .o_count    (w_count),
        .o_head_dat (w_head)
    );

    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.rd_en     = w_issue;
    assign bus.rd_addr   = r_addr;
    assign bus.out_valid = w_valid;
    assign bus.out_data  = w_head[bit_data-1:0];
    assign bus.out_last  = w_valid & w_head[bit_data];
    assign bus.done      = r_zero_done | w_drain_done;

endmodule
